status_register_unit: RTL and testbench
=======================================

# status_register_unit

Holds the architectural NZCV flags for the pipelined ARM core and drives the 4-bit status input of the condition-check logic in the ID stage. Flags are written from the ALU status output of the instruction in EXE when that instruction has its S bit set. A small save/restore stack preserves flags across exception entry and return. The block also resolves the EXE→ID flag hazard, either by forwarding or by raising a stall request.

## Interface
- STACK_DEPTH, 2, number of saved flag entries (1..4)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- aluStatus  input  4  {N,Z,C,V} produced by ALU for the EXE instruction
- exeS  input  1  EXE instruction updates flags
- exeValid  input  1  EXE slot holds a live (non-bubble, non-flushed) instruction
- freeze  input  1  pipeline stall; holds all state
- idCond  input  4  condition field of the instruction in ID
- idValid  input  1  ID slot holds a live instruction
- excEntry  input  1  single-cycle pulse: push current flags
- excReturn  input  1  single-cycle pulse: pop saved flags into register
- errClr  input  1  clears sticky error bits
- statusReg  output  4  {N,Z,C,V} presented to the condition check
- flagHazard  output  1  stall request to the hazard unit
- stackDepth  output  $clog2(STACK_DEPTH+1)  number of valid saved entries
- stackOvf  output  1  sticky: push attempted with stack full
- stackUdf  output  1  sticky: pop attempted with stack empty

## Operation
- State: flags register F[3:0], stack array S[0..STACK_DEPTH-1] of 4 bits, pointer/count cnt, sticky bits ovf and udf.
- `upd = exeValid & exeS & ~freeze`. `next = upd ? aluStatus : F`.
- Priority per cycle (when ~freeze): restore > update.
  - excReturn with cnt>0: F ← S[cnt-1]; cnt decrements. A simultaneous update is dropped.
  - excReturn with cnt==0: F takes next; udf ← 1.
  - Otherwise, F ← next.
- excEntry with cnt<STACK_DEPTH pushes `next`, so the post-update value is saved; cnt increments. With a full stack, no push occurs and ovf ← 1.
- excEntry and excReturn asserted together: treated as a pop only; the push is ignored.
- freeze=1: F, S, cnt, ovf and udf all hold; pulses arriving while frozen are lost.
- errClr clears ovf and udf. A set event in the same cycle wins.
- Hazard condition `haz = idValid & exeValid & exeS & (idCond < 4'b1110)`. Conditions 1110 (always) and 1111 (never) do not depend on flags.
- statusReg and flagHazard follow the Configuration section.

## Timing
- Reset (rst=0, asynchronous): F=4'b0000, cnt=0, ovf=0, udf=0, stack contents cleared. statusReg=0, flagHazard=0, stackDepth=0.
- Register update latency: aluStatus sampled at edge k appears on F after edge k.
- Push/pop take effect at the same edge. stackDepth updates one cycle after the pulse.
- Bypass path (when enabled) is combinational from aluStatus/exeS/exeValid to statusReg in the same cycle.
- Reset deasserting mid-exception discards the stack; no restore is possible afterwards.

## Configuration
- FLAG_BYPASS_EN defined:
  - statusReg = (exeValid & exeS) ? aluStatus : F. This holds during freeze too.
  - flagHazard is tied to 0.
- FLAG_BYPASS_EN undefined:
  - statusReg = F.
  - flagHazard = haz. The hazard unit stalls ID for one cycle, until the flag write retires.

## Test plan
- Reset: drive rst=0 mid-run with F=4'b1010 and cnt=1 → statusReg=0, stackDepth=0, ovf=udf=0 immediately, before any clock edge.
- Update/hold:
  - aluStatus=4'b0110, exeS=1, exeValid=1 for one cycle → F=4'b0110 next cycle.
  - Same stimulus with exeS=0 or freeze=1 → F unchanged.
- Push/pop:
  - F=4'b1001; excEntry → stackDepth=1.
  - Update to 4'b0100, then excReturn → F=4'b1001, stackDepth=0.
  - excReturn together with an update of 4'b1111 → F=4'b1001.
- Overflow/underflow (STACK_DEPTH=2):
  - Three excEntry pulses → stackDepth=2, stackOvf=1.
  - Three excReturn pulses → third pop sets stackUdf=1, F unchanged.
  - errClr → both sticky bits clear.
- Hazard, without FLAG_BYPASS_EN:
  - idCond=4'b0000, idValid=1, EXE exeS=1 → flagHazard=1.
  - Same with idCond=4'b1110 → flagHazard=0.
- Bypass, with FLAG_BYPASS_EN: F=0, aluStatus=4'b0100, exeS=1 → statusReg=4'b0100 in the same cycle and flagHazard=0.

Source files
------------

// File: rtl/status_register_unit.sv
// status_register_unit
// Architectural NZCV flag register for the pipelined core. Flags are written
// from the ALU status of the live EXE instruction when its S bit is set, and a
// small LIFO saves/restores them across exception entry and return. The block
// also resolves the EXE->ID flag dependency for the ID-stage condition check.
//
// Build option: define FLAG_BYPASS_EN to forward the EXE flag result straight
// to statusReg (flagHazard tied low). Without it, statusReg is the register
// and flagHazard asks the hazard unit to stall ID until the flag write retires.
//
// Qualifier semantics: exeValid/idValid mark a live instruction in that slot;
// every EXE/ID-derived action is gated by its valid, and freeze holds all
// state (pulses seen while frozen are dropped, not deferred).
module status_register_unit #(
  parameter int STACK_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [3:0]                         aluStatus,
  input  logic                               exeS,
  input  logic                               exeValid,
  input  logic                               freeze,
  input  logic [3:0]                         idCond,
  input  logic                               idValid,
  input  logic                               excEntry,
  input  logic                               excReturn,
  input  logic                               errClr,
  output logic [3:0]                         statusReg,
  output logic                               flagHazard,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stackDepth,
  output logic                               stackOvf,
  output logic                               stackUdf
);

  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [3:0]    flags_q, flags_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic [3:0]    stack_q [STACK_DEPTH];

  logic          upd;
  logic [3:0]    nxt_flags;
  logic          push_en;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;

  assign upd       = exeValid & exeS & ~freeze;
  assign nxt_flags = upd ? aluStatus : flags_q;

  // Push slot is the current count; top of stack sits one below it. Both are
  // only used when the count makes them in range.
  assign wr_idx  = IW'(cnt_q);
  assign top_idx = IW'(cnt_q - CW'(1));

  // Next-state: restore beats update, a return masks a same-cycle entry, and
  // sticky-bit set events beat errClr.
  always_comb begin
    flags_d = flags_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    push_en = 1'b0;
    if (!freeze) begin
      if (errClr) begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
      if (excReturn) begin
        if (cnt_q != '0) begin
          flags_d = stack_q[top_idx];
          cnt_d   = cnt_q - CW'(1);
        end else begin
          flags_d = nxt_flags;
          udf_d   = 1'b1;
        end
      end else begin
        flags_d = nxt_flags;
        if (excEntry) begin
          if (cnt_q < CW'(STACK_DEPTH)) begin
            push_en = 1'b1;
            cnt_d   = cnt_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
    end
  end

  // Flag register, stack count and sticky error bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Save stack; the post-update flags are what gets pushed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else if (push_en) begin
      stack_q[wr_idx] <= nxt_flags;
    end
  end

  assign stackDepth = cnt_q;
  assign stackOvf   = ovf_q;
  assign stackUdf   = udf_q;

`ifdef FLAG_BYPASS_EN
  // Forward the EXE flag result combinationally, frozen or not.
  assign statusReg  = (exeValid & exeS) ? aluStatus : flags_q;
  assign flagHazard = 1'b0;
  logic unused_id;
  assign unused_id = ^{idCond, idValid};
`else
  // Conditions 1110 (always) and 1111 (never) ignore the flags.
  assign statusReg  = flags_q;
  assign flagHazard = idValid & exeValid & exeS & (idCond < 4'b1110);
`endif

endmodule

// File: tb/tb_status_register_unit.sv
// Self-checking bench for status_register_unit (STACK_DEPTH = 2).
module tb_status_register_unit;

  localparam int DEPTH = 2;

  logic       clk;
  logic       rst;
  logic [3:0] aluStatus;
  logic       exeS, exeValid, freeze;
  logic [3:0] idCond;
  logic       idValid, excEntry, excReturn, errClr;
  logic [3:0] statusReg;
  logic       flagHazard;
  logic [1:0] stackDepth;
  logic       stackOvf, stackUdf;

  status_register_unit #(.STACK_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluStatus  (aluStatus),
    .exeS       (exeS),
    .exeValid   (exeValid),
    .freeze     (freeze),
    .idCond     (idCond),
    .idValid    (idValid),
    .excEntry   (excEntry),
    .excReturn  (excReturn),
    .errClr     (errClr),
    .statusReg  (statusReg),
    .flagHazard (flagHazard),
    .stackDepth (stackDepth),
    .stackOvf   (stackOvf),
    .stackUdf   (stackUdf)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  // Vector layout: {statusReg, flagHazard, stackDepth, stackOvf, stackUdf}
  logic [8:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [3:0] m_f;
  logic [3:0] m_stk[$];
  logic       m_ovf, m_udf;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%b exp=%b (stat,haz,depth,ovf,udf)", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model_out();
    logic [3:0] st;
    logic       hz;
`ifdef FLAG_BYPASS_EN
    st = (exeValid & exeS) ? aluStatus : m_f;
    hz = 1'b0;
`else
    st = m_f;
    hz = idValid & exeValid & exeS & (idCond < 4'd14);
`endif
    return {st, hz, 2'(m_stk.size()), m_ovf, m_udf};
  endfunction

  task automatic model_reset();
    m_f = 4'b0000;
    m_stk.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs held at it.
  task automatic model_step();
    logic [3:0] nxt;
    if (!freeze) begin
      nxt = (exeValid & exeS) ? aluStatus : m_f;
      if (errClr) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (excReturn) begin
        if (m_stk.size() > 0) m_f = m_stk.pop_back();
        else begin
          m_f   = nxt;
          m_udf = 1'b1;
        end
      end else begin
        m_f = nxt;
        if (excEntry) begin
          if (m_stk.size() < DEPTH) m_stk.push_back(nxt);
          else m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic sb_compare(input string tag);
    logic [8:0] e;
    e = exp_q.pop_front();
    check(tag, {statusReg, flagHazard, stackDepth, stackOvf, stackUdf}, e);
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge: apply inputs, check mid-cycle outputs,
  // cross the next edge, return just after it.
  task automatic drive_cycle(input string tag, input logic [3:0] alu, input logic s, input logic v,
                             input logic fz, input logic [3:0] cond, input logic idv,
                             input logic ent, input logic ret, input logic clr);
    aluStatus = alu;
    exeS      = s;
    exeValid  = v;
    freeze    = fz;
    idCond    = cond;
    idValid   = idv;
    excEntry  = ent;
    excReturn = ret;
    errClr    = clr;
    exp_q.push_back(model_out());
    #4;
    sb_compare(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input string tag);
    drive_cycle(tag, 4'h0, 1'b0, 1'b0, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    exp_q.push_back(model_out());
    sb_compare(tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    aluStatus = '0; exeS = 0; exeValid = 0; freeze = 0;
    idCond = 4'hE; idValid = 0; excEntry = 0; excReturn = 0; errClr = 0;
    model_reset();
    #2;
    exp_q.push_back(model_out());
    sb_compare("reset_init");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Update / hold
    drive_cycle("upd_0110",     4'b0110, 1, 1, 0, 4'hE, 0, 0, 0, 0);
    drive_cycle("hold_s0",      4'b1111, 0, 1, 0, 4'hE, 0, 0, 0, 0);
    drive_cycle("hold_freeze",  4'b1111, 1, 1, 1, 4'hE, 0, 0, 0, 0);
    drive_cycle("hold_novalid", 4'b1111, 1, 0, 0, 4'hE, 0, 0, 0, 0);
    idle("after_hold");

    // Push / pop
    drive_cycle("upd_1001",     4'b1001, 1, 1, 0, 4'hE, 0, 0, 0, 0);
    drive_cycle("push1",        4'b0000, 0, 0, 0, 4'hE, 0, 1, 0, 0);
    drive_cycle("upd_0100",     4'b0100, 1, 1, 0, 4'hE, 0, 0, 0, 0);
    drive_cycle("pop1",         4'b0000, 0, 0, 0, 4'hE, 0, 0, 1, 0);
    drive_cycle("push2",        4'b0000, 0, 0, 0, 4'hE, 0, 1, 0, 0);
    drive_cycle("pop_vs_upd",   4'b1111, 1, 1, 0, 4'hE, 0, 0, 1, 0);
    idle("after_pop");

    // Overflow: push sees post-update value
    drive_cycle("ovf_push_a",   4'b0011, 1, 1, 0, 4'hE, 0, 1, 0, 0);
    drive_cycle("ovf_push_b",   4'b0101, 1, 1, 0, 4'hE, 0, 1, 0, 0);
    drive_cycle("ovf_push_c",   4'b0111, 1, 1, 0, 4'hE, 0, 1, 0, 0);
    drive_cycle("ovf_push_clr", 4'b0000, 0, 0, 0, 4'hE, 0, 1, 0, 1);
    idle("ovf_seen");

    // Underflow
    drive_cycle("udf_pop_a",    4'b0000, 0, 0, 0, 4'hE, 0, 0, 1, 0);
    drive_cycle("udf_pop_b",    4'b0000, 0, 0, 0, 4'hE, 0, 0, 1, 0);
    drive_cycle("udf_pop_c",    4'b0000, 0, 0, 0, 4'hE, 0, 0, 1, 0);
    idle("udf_seen");
    drive_cycle("err_clr",      4'b0000, 0, 0, 0, 4'hE, 0, 0, 0, 1);
    idle("err_cleared");

    // Entry+return together is a pop only; frozen pulses are lost
    drive_cycle("push3",        4'b1100, 1, 1, 0, 4'hE, 0, 1, 0, 0);
    drive_cycle("ent_and_ret",  4'b0000, 0, 0, 0, 4'hE, 0, 1, 1, 0);
    drive_cycle("frz_push",     4'b1010, 1, 1, 1, 4'hE, 0, 1, 0, 0);
    drive_cycle("frz_pop",      4'b0000, 0, 0, 1, 4'hE, 0, 0, 1, 0);
    idle("after_freeze");

    // Hazard detection
    drive_cycle("haz_c0",       4'b0001, 1, 1, 0, 4'h0, 1, 0, 0, 0);
    drive_cycle("haz_cE",       4'b0001, 1, 1, 0, 4'hE, 1, 0, 0, 0);
    drive_cycle("haz_cF",       4'b0001, 1, 1, 0, 4'hF, 1, 0, 0, 0);
    drive_cycle("haz_cD",       4'b0001, 1, 1, 0, 4'hD, 1, 0, 0, 0);
    drive_cycle("haz_idinv",    4'b0001, 1, 1, 0, 4'h0, 0, 0, 0, 0);
    drive_cycle("haz_s0",       4'b0001, 0, 1, 0, 4'h0, 1, 0, 0, 0);

    // Bypass-visible case (F=0 then aluStatus=0100)
    async_reset("reset_pre_byp");
    drive_cycle("byp_0100",     4'b0100, 1, 1, 0, 4'hE, 0, 0, 0, 0);
    idle("byp_after");

    // Mid-run async reset with F=1010, cnt=1
    drive_cycle("pre_rst_upd",  4'b1010, 1, 1, 0, 4'hE, 0, 1, 0, 0);
    drive_cycle("pre_rst_ovf",  4'b0000, 0, 0, 0, 4'hE, 0, 0, 0, 0);
    async_reset("reset_midrun");
    drive_cycle("post_rst_pop", 4'b0000, 0, 0, 0, 4'hE, 0, 0, 1, 0);
    idle("post_rst");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive_cycle("rand",
                  4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 7) == 0),
                  4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
